// File: rtl/snake_grid_if.sv
// Grid writer/reader bundle between the snake engine and the segment mapper.
interface snake_grid_if;
  logic [35:0] cells;
  logic [3:0]  head_r;
  logic [1:0]  head_c;
  logic [1:0]  dir;
  logic        step;
  logic        paused;
  logic        game_over;

  modport master (
    output cells, head_r, head_c,
    output dir, step, paused, game_over
  );

  modport slave (
    input cells, head_r, head_c,
    input dir, step, paused, game_over
  );
endinterface

// File: rtl/snake_engine.sv
// Snake game-state engine: move timer, position history,
// self-collision and 12x3 occupancy grid writer.
module snake_engine #(
  parameter int TICK_UNIT = 1_000_000,
  parameter int MAX_LEN   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] button,
  input  logic [3:0] sw,
  snake_grid_if.master g
);

  localparam int LW = $clog2(MAX_LEN + 1);
  localparam logic [23:0] TU = 24'(TICK_UNIT);

  typedef enum logic [1:0] {
    TURN_NONE,
    TURN_L,
    TURN_R
  } turn_e;

  logic [2:0]    sync1_q, sync2_q, prev_q;
  logic [2:0]    pulse;
  logic [23:0]   cnt_q, cnt_d, term;
  turn_e         turn_q, turn_d;
  logic [1:0]    dir_q, dir_d, nd;
  logic [LW-1:0] len_q, len_d, sw_len;
  logic [3:0]    pos_r_q [MAX_LEN];
  logic [3:0]    pos_r_d [MAX_LEN];
  logic [1:0]    pos_c_q [MAX_LEN];
  logic [1:0]    pos_c_d [MAX_LEN];
  logic [35:0]   cells_q, cells_d;
  logic          step_q, step_d;
  logic          paused_q, paused_d;
  logic          over_q, over_d;
  logic          tick, hit, restart;
  logic [3:0]    nr;
  logic [1:0]    nc;
  logic [5:0]    idx;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
    end else begin
      sync1_q <= button;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign pulse = sync2_q & ~prev_q;

  always_comb begin
    if (int'(sw[3:2]) + 1 > MAX_LEN)
      sw_len = LW'(MAX_LEN);
    else
      sw_len = LW'(int'(sw[3:2]) + 1);
  end

  assign term = ({22'd0, sw[1:0]} + 24'd1) * TU - 24'd1;
  assign restart = pulse[2] & over_q;
  assign tick = !paused_q && !over_q && (cnt_q >= term);

  always_comb begin
    unique case (turn_q)
      TURN_L:  nd = dir_q - 2'd1;
      TURN_R:  nd = dir_q + 2'd1;
      default: nd = dir_q;
    endcase
  end

  always_comb begin
    nr = pos_r_q[0];
    nc = pos_c_q[0];
    unique case (nd)
      2'd0: nr = (pos_r_q[0] == 4'd0) ? 4'd11 : pos_r_q[0] - 4'd1;
      2'd1: nc = (pos_c_q[0] == 2'd2) ? 2'd0 : pos_c_q[0] + 2'd1;
      2'd2: nr = (pos_r_q[0] == 4'd11) ? 4'd0 : pos_r_q[0] + 4'd1;
      2'd3: nc = (pos_c_q[0] == 2'd0) ? 2'd2 : pos_c_q[0] - 2'd1;
    endcase
  end

  // The tail slot vacates on a move, so it is excluded from the check.
  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < MAX_LEN - 1; i++) begin
      if (i + 1 < int'(len_q) &&
          pos_r_q[i] == nr && pos_c_q[i] == nc)
        hit = 1'b1;
    end
  end

  always_comb begin
    cnt_d    = cnt_q;
    turn_d   = turn_q;
    dir_d    = dir_q;
    len_d    = len_q;
    pos_r_d  = pos_r_q;
    pos_c_d  = pos_c_q;
    step_d   = 1'b0;
    paused_d = paused_q;
    over_d   = over_q;

    if (!paused_q && !over_q)
      cnt_d = tick ? 24'd0 : cnt_q + 24'd1;

    if (tick) begin
      dir_d  = nd;
      turn_d = TURN_NONE;
      if (hit) begin
        over_d = 1'b1;
      end else begin
        step_d = 1'b1;
        for (int i = MAX_LEN - 1; i > 0; i--) begin
          pos_r_d[i] = pos_r_q[i-1];
          pos_c_d[i] = pos_c_q[i-1];
        end
        pos_r_d[0] = nr;
        pos_c_d[0] = nc;
      end
    end

    // A turn arriving with a tick is kept for the next move.
    if (pulse[0] ^ pulse[1])
      turn_d = pulse[0] ? TURN_L : TURN_R;

    if (pulse[2] && !over_q)
      paused_d = !paused_q;

    if (restart) begin
      len_d    = sw_len;
      dir_d    = 2'd0;
      turn_d   = TURN_NONE;
      cnt_d    = 24'd0;
      over_d   = 1'b0;
      paused_d = 1'b0;
      step_d   = 1'b0;
      for (int i = 0; i < MAX_LEN; i++) begin
        pos_r_d[i] = 4'd5;
        pos_c_d[i] = 2'd1;
      end
    end
  end

  always_comb begin
    cells_d = '0;
    idx     = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      if (i < int'(len_d)) begin
        idx = 6'(pos_r_d[i]) * 6'd3 + 6'(pos_c_d[i]);
        cells_d = cells_d | (36'd1 << idx);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q    <= '0;
      turn_q   <= TURN_NONE;
      dir_q    <= '0;
      len_q    <= LW'(MAX_LEN);
      cells_q  <= 36'h0_0001_0000;
      step_q   <= 1'b0;
      paused_q <= 1'b0;
      over_q   <= 1'b0;
      for (int i = 0; i < MAX_LEN; i++) begin
        pos_r_q[i] <= 4'd5;
        pos_c_q[i] <= 2'd1;
      end
    end else begin
      cnt_q    <= cnt_d;
      turn_q   <= turn_d;
      dir_q    <= dir_d;
      len_q    <= len_d;
      cells_q  <= cells_d;
      step_q   <= step_d;
      paused_q <= paused_d;
      over_q   <= over_d;
      pos_r_q  <= pos_r_d;
      pos_c_q  <= pos_c_d;
    end
  end

  assign g.cells     = cells_q;
  assign g.head_r    = pos_r_q[0];
  assign g.head_c    = pos_c_q[0];
  assign g.dir       = dir_q;
  assign g.step      = step_q;
  assign g.paused    = paused_q;
  assign g.game_over = over_q;

endmodule

// File: tb/tb_snake_engine.sv
// Directed bench for snake_engine with TICK_UNIT=4, MAX_LEN=4.
module tb_snake_engine;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] button = 3'b0;
  logic [3:0] sw = 4'b0;
  int checks = 0;
  int errors = 0;

  snake_grid_if gif();

  snake_engine #(
    .TICK_UNIT(4),
    .MAX_LEN(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .button(button),
    .sw(sw),
    .g(gif)
  );

  always #5 clk = ~clk;

  task automatic do_reset(input logic [3:0] s);
    sw  = s;
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic press(input logic [2:0] b);
    button = b;
    @(negedge clk);
    @(negedge clk);
    button = 3'b0;
  endtask

  task automatic wait_move(input int max, output int n, output bit got);
    bit done;
    n = 0;
    got = 1'b0;
    done = 1'b0;
    while (!done && n < max) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (gif.step || gif.game_over) begin
        got = gif.step;
        done = 1'b1;
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL wait_move timeout after %0d cycles", n);
    end
  endtask

  task automatic chk_head(input string nm, input int r, input int c);
    checks++;
    if (gif.head_r !== 4'(r) || gif.head_c !== 2'(c)) begin
      errors++;
      $display("FAIL %s head got (%0d,%0d) want (%0d,%0d)",
               nm, gif.head_r, gif.head_c, r, c);
    end
  endtask

  task automatic test_reset;
    #1 rst = 1'b0;
    #1;
    checks++;
    if (gif.cells !== 36'h0_0001_0000) begin
      errors++;
      $display("FAIL rst_cells got %h want %h", gif.cells, 36'h10000);
    end
    chk_head("rst", 5, 1);
    checks++;
    if ({gif.dir, gif.step, gif.paused, gif.game_over} !== 5'b0) begin
      errors++;
      $display("FAIL rst_flags got %b want 00000",
               {gif.dir, gif.step, gif.paused, gif.game_over});
    end
  endtask

  task automatic test_first_step;
    int n;
    bit got;
    do_reset(4'b0000);
    wait_move(20, n, got);
    checks++;
    if (n !== 4 || got !== 1'b1) begin
      errors++;
      $display("FAIL first_step got n=%0d step=%0d want n=4 step=1", n, got);
    end
    chk_head("first", 4, 1);
    checks++;
    if (gif.cells !== 36'h0_0001_2000) begin
      errors++;
      $display("FAIL first_cells got %h want %h", gif.cells, 36'h12000);
    end
    wait_move(20, n, got);
    checks++;
    if (n !== 4) begin
      errors++;
      $display("FAIL period4 got %0d want 4", n);
    end
    chk_head("second", 3, 1);
    checks++;
    if (gif.cells !== 36'h0_0001_2400) begin
      errors++;
      $display("FAIL second_cells got %h want %h", gif.cells, 36'h12400);
    end
  endtask

  task automatic test_wrap;
    int n;
    int exp_r;
    bit got;
    do_reset(4'b0011);
    for (int k = 1; k <= 12; k++) begin
      wait_move(40, n, got);
      exp_r = (5 - k + 12) % 12;
      checks++;
      if (n !== 16) begin
        errors++;
        $display("FAIL period16 move %0d got %0d want 16", k, n);
      end
      chk_head("wrap", exp_r, 1);
    end
    checks++;
    if (gif.cells !== 36'h0_0249_0000 || gif.game_over !== 1'b0) begin
      errors++;
      $display("FAIL wrap_cells got %h go=%0d want %h go=0",
               gif.cells, gif.game_over, 36'h2490000);
    end
  endtask

  task automatic test_turn;
    int n;
    bit got;
    press(3'b011);
    wait_move(40, n, got);
    checks++;
    if (gif.dir !== 2'd0) begin
      errors++;
      $display("FAIL lr_discard dir got %0d want 0", gif.dir);
    end
    chk_head("lr", 4, 1);
    press(3'b010);
    wait_move(40, n, got);
    checks++;
    if (gif.dir !== 2'd1) begin
      errors++;
      $display("FAIL turn_right dir got %0d want 1", gif.dir);
    end
    chk_head("right", 4, 2);
    wait_move(40, n, got);
    chk_head("colwrap", 4, 0);
    checks++;
    if (gif.game_over !== 1'b0 || got !== 1'b1) begin
      errors++;
      $display("FAIL colwrap go=%0d step=%0d want 0/1", gif.game_over, got);
    end
  endtask

  task automatic test_collision;
    int n;
    int seen;
    bit got;
    wait_move(40, n, got);
    checks++;
    if (gif.game_over !== 1'b1 || got !== 1'b0 || gif.step !== 1'b0) begin
      errors++;
      $display("FAIL collide go=%0d step=%0d want 1/0", gif.game_over, got);
    end
    checks++;
    if (gif.cells !== 36'h0_0001_7000) begin
      errors++;
      $display("FAIL collide_cells got %h want %h", gif.cells, 36'h17000);
    end
    chk_head("collide", 4, 0);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (gif.step) seen++;
    end
    checks++;
    if (seen !== 0 || gif.cells !== 36'h0_0001_7000) begin
      errors++;
      $display("FAIL frozen steps=%0d cells=%h want 0 %h",
               seen, gif.cells, 36'h17000);
    end
  endtask

  task automatic test_restart;
    int n;
    bit got;
    sw = 4'b0100;
    press(3'b100);
    @(negedge clk);
    checks++;
    if (gif.game_over !== 1'b0 || gif.paused !== 1'b0 || gif.dir !== 2'd0) begin
      errors++;
      $display("FAIL restart go=%0d p=%0d dir=%0d want 0/0/0",
               gif.game_over, gif.paused, gif.dir);
    end
    chk_head("restart", 5, 1);
    checks++;
    if (gif.cells !== 36'h0_0001_0000) begin
      errors++;
      $display("FAIL restart_cells got %h want %h", gif.cells, 36'h10000);
    end
    wait_move(20, n, got);
    checks++;
    if (n !== 4 || gif.cells !== 36'h0_0001_2000) begin
      errors++;
      $display("FAIL len2_a n=%0d cells=%h want 4 %h", n, gif.cells, 36'h12000);
    end
    wait_move(20, n, got);
    chk_head("len2", 3, 1);
    checks++;
    if (gif.cells !== 36'h0_0000_2400) begin
      errors++;
      $display("FAIL len2_cells got %h want %h", gif.cells, 36'h2400);
    end
  endtask

  task automatic test_pause;
    int n;
    int seen;
    bit got;
    sw = 4'b0111;
    wait_move(40, n, got);
    checks++;
    if (n !== 16 || gif.cells !== 36'h0_0000_0480) begin
      errors++;
      $display("FAIL live_speed n=%0d cells=%h want 16 %h", n, gif.cells, 36'h480);
    end
    repeat (4) @(negedge clk);
    press(3'b100);
    @(negedge clk);
    checks++;
    if (gif.paused !== 1'b1) begin
      errors++;
      $display("FAIL pause_on got %0d want 1", gif.paused);
    end
    seen = 0;
    repeat (30) begin
      @(negedge clk);
      if (gif.step) seen++;
    end
    checks++;
    if (seen !== 0 || gif.paused !== 1'b1) begin
      errors++;
      $display("FAIL paused_hold steps=%0d p=%0d want 0/1", seen, gif.paused);
    end
    press(3'b100);
    wait_move(40, n, got);
    checks++;
    if (n !== 10 || gif.paused !== 1'b0) begin
      errors++;
      $display("FAIL resume n=%0d p=%0d want 10/0", n, gif.paused);
    end
    chk_head("resume", 1, 1);
    checks++;
    if (gif.cells !== 36'h0_0000_0090) begin
      errors++;
      $display("FAIL resume_cells got %h want %h", gif.cells, 36'h90);
    end
  endtask

  task automatic test_async_reset;
    #2 rst = 1'b0;
    #1;
    checks++;
    if (gif.cells !== 36'h0_0001_0000 || gif.step !== 1'b0) begin
      errors++;
      $display("FAIL async_rst cells=%h step=%0d want %h 0",
               gif.cells, gif.step, 36'h10000);
    end
    chk_head("async_rst", 5, 1);
    checks++;
    if ({gif.dir, gif.paused, gif.game_over} !== 4'b0) begin
      errors++;
      $display("FAIL async_flags got %b want 0000",
               {gif.dir, gif.paused, gif.game_over});
    end
    sw = 4'b0011;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_tail_chase;
    int n;
    bit got;
    wait_move(40, n, got);
    chk_head("tc_up", 4, 1);
    press(3'b010);
    wait_move(40, n, got);
    chk_head("tc_right", 4, 2);
    press(3'b010);
    wait_move(40, n, got);
    chk_head("tc_down", 5, 2);
    press(3'b010);
    wait_move(40, n, got);
    chk_head("tc_left", 5, 1);
    checks++;
    if (gif.cells !== 36'h0_0003_6000 || gif.game_over !== 1'b0 || gif.dir !== 2'd3) begin
      errors++;
      $display("FAIL tail_a cells=%h go=%0d dir=%0d want %h 0 3",
               gif.cells, gif.game_over, gif.dir, 36'h36000);
    end
    press(3'b010);
    wait_move(40, n, got);
    chk_head("tc_up2", 4, 1);
    checks++;
    if (got !== 1'b1 || gif.game_over !== 1'b0 || gif.cells !== 36'h0_0003_6000) begin
      errors++;
      $display("FAIL tail_b step=%0d go=%0d cells=%h want 1 0 %h",
               got, gif.game_over, gif.cells, 36'h36000);
    end
  endtask

  initial begin
    test_reset();
    test_first_step();
    test_wrap();
    test_turn();
    test_collision();
    test_restart();
    test_pause();
    test_async_reset();
    test_tail_chase();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
